// File: rtl/context_spill_unit.sv
// Saves the four-register context (mary/shelley/comp/ra) to memory on kernel entry and
// reloads it through the register block's memval path on kernel exit.
module context_spill_unit #(
    parameter int unsigned WORD_STRIDE = 2
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        save_req,
    input  logic        restore_req,
    input  logic [15:0] base_addr,
    input  logic [15:0] mary_in,
    input  logic [15:0] shelley_in,
    input  logic [15:0] comp_in,
    input  logic [15:0] ra_in,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] memval,
    output logic        mary_write,
    output logic        shelley_write,
    output logic        comp_write,
    output logic        ra_write,
    output logic        busy,
    output logic        done,
    output logic        in_kernel
);
    typedef enum logic [2:0] {IDLE, SAVE, RD, WB, DONE} state_t;

    localparam logic [15:0] STRIDE = 16'(WORD_STRIDE);

    state_t           state_reg, state_next;
    logic [1:0]       idx_reg, idx_next;
    logic [15:0]      base_reg, base_next;
    logic [15:0]      memval_reg, memval_next;
    logic             kernel_reg, kernel_next;
    logic             op_save_reg, op_save_next;
    logic             accept_save;
    logic [3:0][15:0] reg_vec;
    logic [3:0][15:0] snap_reg;
    logic [15:0]      word_addr;
    logic [3:0]       wr_vec;

    assign reg_vec   = {ra_in, comp_in, shelley_in, mary_in};
    // Address wraps naturally at 16 bits.
    assign word_addr = base_reg + STRIDE * 16'(idx_reg);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            idx_reg     <= 2'd0;
            base_reg    <= 16'd0;
            memval_reg  <= 16'd0;
            kernel_reg  <= 1'b0;
            op_save_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            idx_reg     <= idx_next;
            base_reg    <= base_next;
            memval_reg  <= memval_next;
            kernel_reg  <= kernel_next;
            op_save_reg <= op_save_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            snap_reg <= '0;
        end else if (accept_save) begin
            snap_reg <= reg_vec;
        end
    end

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        base_next    = base_reg;
        memval_next  = memval_reg;
        kernel_next  = kernel_reg;
        op_save_next = op_save_reg;
        accept_save  = 1'b0;
        mem_addr     = 16'd0;
        mem_wdata    = 16'd0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        done         = 1'b0;

        case (state_reg)
            IDLE: begin
                // Save has priority; which one is legal depends on the kernel flag anyway.
                if (save_req && !kernel_reg) begin
                    accept_save  = 1'b1;
                    base_next    = base_addr;
                    idx_next     = 2'd0;
                    op_save_next = 1'b1;
                    state_next   = SAVE;
                end else if (restore_req && kernel_reg) begin
                    base_next    = base_addr;
                    idx_next     = 2'd0;
                    op_save_next = 1'b0;
                    state_next   = RD;
                end
            end
            SAVE: begin
                mem_we    = 1'b1;
                mem_addr  = word_addr;
                mem_wdata = snap_reg[idx_reg];
                if (mem_ready) begin
                    if (idx_reg == 2'd3) begin
                        state_next = DONE;
                    end else begin
                        idx_next = idx_reg + 2'd1;
                    end
                end
            end
            RD: begin
                mem_re   = 1'b1;
                mem_addr = word_addr;
                if (mem_ready) begin
                    memval_next = mem_rdata;
                    state_next  = WB;
                end
            end
            WB: begin
                if (idx_reg == 2'd3) begin
                    state_next = DONE;
                end else begin
                    idx_next   = idx_reg + 2'd1;
                    state_next = RD;
                end
            end
            DONE: begin
                done        = 1'b1;
                kernel_next = op_save_reg;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_wr
            assign wr_vec[gi] = (state_reg == WB) && (idx_reg == 2'(gi));
        end
    endgenerate

    assign mary_write    = wr_vec[0];
    assign shelley_write = wr_vec[1];
    assign comp_write    = wr_vec[2];
    assign ra_write      = wr_vec[3];
    assign memval        = memval_reg;
    assign busy          = (state_reg != IDLE);
    assign in_kernel     = kernel_reg;

endmodule

// File: tb/tb_context_spill_unit.sv
// Scoreboard bench for context_spill_unit: stimulus queues expected events, a negedge
// monitor pops and compares each observed memory access, register write and flag change.
module tb_context_spill_unit;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        save_req = 1'b0;
    logic        restore_req = 1'b0;
    logic [15:0] base_addr = 16'd0;
    logic [15:0] mary_in = 16'd0;
    logic [15:0] shelley_in = 16'd0;
    logic [15:0] comp_in = 16'd0;
    logic [15:0] ra_in = 16'd0;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic        mem_ready = 1'b1;
    logic [15:0] memval;
    logic        mary_write, shelley_write, comp_write, ra_write;
    logic        busy, done, in_kernel;

    logic [15:0] rd_table [4];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    // kinds: 0 write, 1 write stall, 2 read, 3..6 mary..ra write, 7 done, 8 in_kernel change
    typedef struct {
        int          kind;
        logic [15:0] addr;
        logic [15:0] data;
        int          at;
    } ev_t;
    ev_t exp_q[$];

    context_spill_unit #(.WORD_STRIDE(2)) dut (
        .clock(clock), .reset(reset), .save_req(save_req), .restore_req(restore_req),
        .base_addr(base_addr), .mary_in(mary_in), .shelley_in(shelley_in),
        .comp_in(comp_in), .ra_in(ra_in), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .memval(memval), .mary_write(mary_write), .shelley_write(shelley_write),
        .comp_write(comp_write), .ra_write(ra_write), .busy(busy), .done(done),
        .in_kernel(in_kernel)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    assign mem_rdata = rd_table[mem_addr[2:1]];

    task automatic push(input int kind, input logic [15:0] addr, input logic [15:0] data,
                        input int at);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.at = at;
        exp_q.push_back(e);
    endtask

    task automatic got(input int kind, input logic [15:0] addr, input logic [15:0] data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind=%0d addr=%h data=%h cyc=%0d, required none",
                     kind, addr, data, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.addr != addr || e.data != data || e.at != cyc) begin
                errors++;
                $display("FAIL event: got kind=%0d addr=%h data=%h cyc=%0d, required kind=%0d addr=%h data=%h cyc=%0d",
                         kind, addr, data, cyc, e.kind, e.addr, e.data, e.at);
            end else begin
                $display("ok   event kind=%0d addr=%h data=%h cyc=%0d", kind, addr, data, cyc);
            end
        end
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("ok   %s = %h", name, act);
        end
    endtask

    // Monitor
    initial begin
        logic prev_kernel;
        prev_kernel = 1'b0;
        forever begin
            @(negedge clock);
            if (mem_we && mem_ready)  got(0, mem_addr, mem_wdata);
            if (mem_we && !mem_ready) got(1, mem_addr, mem_wdata);
            if (mem_re && mem_ready)  got(2, mem_addr, mem_rdata);
            if (mary_write)    got(3, 16'd0, memval);
            if (shelley_write) got(4, 16'd0, memval);
            if (comp_write)    got(5, 16'd0, memval);
            if (ra_write)      got(6, 16'd0, memval);
            if (done)          got(7, 16'd0, 16'd0);
            if (in_kernel != prev_kernel) got(8, 16'd0, {15'd0, in_kernel});
            prev_kernel = in_kernel;
            if ((mem_we && mem_re) ||
                (!busy && (mem_we || mem_re || mem_addr != 16'd0 || mem_wdata != 16'd0 ||
                           mary_write || shelley_write || comp_write || ra_write || done))) begin
                checks++;
                errors++;
                $display("FAIL idle_or_strobe: cyc=%0d busy=%b we=%b re=%b addr=%h wdata=%h, required quiet outputs",
                         cyc, busy, mem_we, mem_re, mem_addr, mem_wdata);
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic set_regs(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
        mary_in = a; shelley_in = b; comp_in = c; ra_in = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rd_table[0] = 16'hAAAA; rd_table[1] = 16'hBBBB;
        rd_table[2] = 16'hCCCC; rd_table[3] = 16'hDDDD;

        // Reset state
        repeat (3) next_cycle();
        check("reset_busy", {15'd0, busy}, 16'd0);
        check("reset_in_kernel", {15'd0, in_kernel}, 16'd0);
        check("reset_memval", memval, 16'd0);
        check("reset_mem_addr", mem_addr, 16'd0);
        reset = 1'b1;
        repeat (2) next_cycle();

        // Save with restore_req also high; inputs disturbed after accept; requests while busy
        t = cyc;
        set_regs(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        base_addr = 16'h0100; save_req = 1'b1; restore_req = 1'b1;
        push(0, 16'h0100, 16'h1111, t + 1);
        push(0, 16'h0102, 16'h2222, t + 2);
        push(0, 16'h0104, 16'h3333, t + 3);
        push(0, 16'h0106, 16'h4444, t + 4);
        push(7, 16'd0, 16'd0, t + 5);
        push(8, 16'd0, 16'd1, t + 6);
        next_cycle();
        save_req = 1'b0; restore_req = 1'b0;
        set_regs(16'hDEAD, 16'hBEEF, 16'hF00D, 16'hCAFE);
        base_addr = 16'h5555;
        next_cycle();
        save_req = 1'b1; restore_req = 1'b1;
        next_cycle();
        save_req = 1'b0; restore_req = 1'b0;
        repeat (8) next_cycle();
        check("in_kernel_after_save", {15'd0, in_kernel}, 16'd1);

        // Save while in kernel is ignored
        save_req = 1'b1;
        next_cycle();
        save_req = 1'b0;
        repeat (3) next_cycle();

        // Restore
        t = cyc;
        base_addr = 16'h0100; restore_req = 1'b1;
        push(2, 16'h0100, 16'hAAAA, t + 1);
        push(3, 16'd0, 16'hAAAA, t + 2);
        push(2, 16'h0102, 16'hBBBB, t + 3);
        push(4, 16'd0, 16'hBBBB, t + 4);
        push(2, 16'h0104, 16'hCCCC, t + 5);
        push(5, 16'd0, 16'hCCCC, t + 6);
        push(2, 16'h0106, 16'hDDDD, t + 7);
        push(6, 16'd0, 16'hDDDD, t + 8);
        push(7, 16'd0, 16'd0, t + 9);
        push(8, 16'd0, 16'd0, t + 10);
        next_cycle();
        restore_req = 1'b0;
        repeat (12) next_cycle();

        // Save with three stall cycles on word 1
        t = cyc;
        set_regs(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        base_addr = 16'h0100; save_req = 1'b1;
        push(0, 16'h0100, 16'h1111, t + 1);
        push(1, 16'h0102, 16'h2222, t + 2);
        push(1, 16'h0102, 16'h2222, t + 3);
        push(1, 16'h0102, 16'h2222, t + 4);
        push(0, 16'h0102, 16'h2222, t + 5);
        push(0, 16'h0104, 16'h3333, t + 6);
        push(0, 16'h0106, 16'h4444, t + 7);
        push(7, 16'd0, 16'd0, t + 8);
        push(8, 16'd0, 16'd1, t + 9);
        next_cycle();
        save_req = 1'b0;
        next_cycle();
        mem_ready = 1'b0;
        repeat (3) next_cycle();
        mem_ready = 1'b1;
        repeat (8) next_cycle();

        // Restore interrupted by reset during the read of word 2
        rd_table[0] = 16'h1234; rd_table[1] = 16'h5678;
        t = cyc;
        base_addr = 16'h0100; restore_req = 1'b1;
        push(2, 16'h0100, 16'h1234, t + 1);
        push(3, 16'd0, 16'h1234, t + 2);
        push(2, 16'h0102, 16'h5678, t + 3);
        push(4, 16'd0, 16'h5678, t + 4);
        push(8, 16'd0, 16'd0, t + 5);
        next_cycle();
        restore_req = 1'b0;
        repeat (4) next_cycle();
        reset = 1'b0;
        #1;
        check("rst_mem_re", {15'd0, mem_re}, 16'd0);
        check("rst_mem_addr", mem_addr, 16'd0);
        check("rst_busy", {15'd0, busy}, 16'd0);
        check("rst_memval", memval, 16'd0);
        check("rst_in_kernel", {15'd0, in_kernel}, 16'd0);
        repeat (2) next_cycle();

        // First request right after reset release, with address wrap
        reset = 1'b1;
        t = cyc;
        set_regs(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
        base_addr = 16'hFFFC; save_req = 1'b1;
        push(0, 16'hFFFC, 16'h0A0A, t + 1);
        push(0, 16'hFFFE, 16'h0B0B, t + 2);
        push(0, 16'h0000, 16'h0C0C, t + 3);
        push(0, 16'h0002, 16'h0D0D, t + 4);
        push(7, 16'd0, 16'd0, t + 5);
        push(8, 16'd0, 16'd1, t + 6);
        next_cycle();
        save_req = 1'b0;
        repeat (10) next_cycle();

        while (exp_q.size() > 0) begin
            ev_t e;
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event: got none, required kind=%0d addr=%h data=%h cyc=%0d",
                     e.kind, e.addr, e.data, e.at);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
